ctrl_seq: RTL
=============

CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset).
REQ-003 SHALL have port start, input, 1, run request; sampled only in IDLE or HALT.
REQ-004 SHALL have port instr, input, 16, program-memory read data; synchronous read, valid one cycle after the address changes.
REQ-005 SHALL have port zero, input, 1, datapath zero flag, sampled in EXEC.
REQ-006 SHALL have port pc_start, output, 1, program counter load-1 strobe.
REQ-007 SHALL have port pc_inc, output, 1, program counter increment strobe.
REQ-008 SHALL have port pc_branch, output, 1, program counter load-from-bus strobe.
REQ-009 SHALL have port bus, output, 16, branch target: {10'b0, ir[5:0]} while pc_branch=1, else 16'h0000.
REQ-010 SHALL have port alu_en, output, 1, datapath execute strobe.
REQ-011 SHALL have port alu_op, output, 4, ir[15:12], valid while alu_en=1, else 4'h0.
REQ-012 SHALL have port ir, output, 16, current instruction register.
REQ-013 SHALL have port done, output, 1, high while in HALT.
REQ-014 SHALL have port instr_cnt, output, 16, retired-instruction count.

Function
REQ-015 SHALL implement FSM with states IDLE, LOAD, FETCH, DECODE, EXEC, HALT.
REQ-016 IDLE: start=1 -> LOAD; else stay.
REQ-017 LOAD: pc_start=1 for exactly one cycle; instr_cnt cleared to 0; -> FETCH.
REQ-018 FETCH: no strobes; -> DECODE (memory read in flight).
REQ-019 DECODE: ir <= instr; -> EXEC.
REQ-020 EXEC: exactly one strobe set asserted for one cycle, decoded from ir[15:12]; instr_cnt incremented; -> FETCH, except HALT opcode -> HALT.
REQ-021 Opcode 4'h0 NOP: pc_inc=1.
REQ-022 Opcode 4'h1 JMP: pc_branch=1, bus = {10'b0, ir[5:0]}.
REQ-023 Opcode 4'h2 BZ: zero=1 -> as JMP; zero=0 -> pc_inc=1.
REQ-024 Opcode 4'hF HALT: no PC strobe; done=1 from next cycle.
REQ-025 Opcodes 4'h3-4'hE: alu_en=1, alu_op=ir[15:12], pc_inc=1 same cycle.
REQ-026 HALT: done=1; start=1 -> LOAD; else stay.
REQ-027 Outputs pc_start, pc_inc, pc_branch, alu_en, bus, alu_op SHALL be decoded combinationally from state and ir; at most one of pc_start/pc_inc/pc_branch high in any cycle.
REQ-028 Instruction latency SHALL be 3 cycles (FETCH, DECODE, EXEC) per instruction.
REQ-029 start outside IDLE/HALT SHALL be ignored.
REQ-030 instr_cnt SHALL saturate at 16'hFFFF (no wrap).
REQ-031 Branch target upper bits ir[11:6] SHALL be ignored; PC wrap 63->0 is PC-side and needs no sequencer action.
REQ-032 HALT retirement SHALL count in instr_cnt.

Reset
REQ-033 rst=0 SHALL asynchronously force state IDLE, ir=16'h0000, instr_cnt=16'h0000, all strobes 0, bus=16'h0000, done=0.
REQ-034 Reset mid-instruction SHALL abort it with no strobe emitted after rst falls; operation resumes only via start.

Structure
REQ-035 Package ctrl_pkg SHALL hold the state enum and opcode constants (OP_NOP, OP_JMP, OP_BZ, OP_HALT).
REQ-036 Combinational opcode-to-strobe decode SHALL be sub-module ctrl_dec; FSM, ir and counter stay in ctrl_seq.

Verification
REQ-037 Reset then start=1 one cycle -> pc_start=1 exactly one cycle later, state FETCH next, instr_cnt=0.
REQ-038 instr=16'h1025 (JMP) -> in EXEC pc_branch=1, bus=16'h0025, pc_inc=0; next state FETCH; instr_cnt=1.
REQ-039 instr=16'h2007 with zero=1 -> pc_branch=1, bus=16'h0007; repeat with zero=0 -> pc_inc=1, bus=16'h0000.
REQ-040 instr=16'h3000 -> alu_en=1, alu_op=4'h3, pc_inc=1 same cycle; then instr=16'hF000 -> done=1, no strobes; start=1 -> LOAD, instr_cnt=0.
REQ-041 rst=0 asserted during DECODE -> all outputs 0 immediately; start held 1 -> no activity until rst=1, then LOAD.
REQ-042 instr_cnt forced to 16'hFFFE, two NOP retirements -> instr_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: sequencer state encoding and opcode constants shared by ctrl_seq and ctrl_dec.
package ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_BZ   = 4'h2;
    localparam logic [3:0] OP_HALT = 4'hF;
endpackage

// File: rtl/ctrl_dec.sv
// ctrl_dec: combinational strobe decode from sequencer state, instruction register and zero flag.
module ctrl_dec
    import ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [15:0] ir,
    input  logic        zero,
    output logic        pc_start,
    output logic        pc_inc,
    output logic        pc_branch,
    output logic [15:0] bus,
    output logic        alu_en,
    output logic [3:0]  alu_op
);
    logic [3:0] op;
    logic       ex;
    logic       take;
    assign op = ir[15:12];
    always_comb begin
        ex        = state == S_EXEC;
        take      = ex && (op == OP_JMP || (op == OP_BZ && zero));
        pc_start  = state == S_LOAD;
        pc_branch = take;
        pc_inc    = ex && !take && op != OP_HALT;
        // every opcode outside NOP/JMP/BZ/HALT is a datapath operation
        alu_en    = ex && op != OP_NOP && op != OP_JMP && op != OP_BZ && op != OP_HALT;
        alu_op    = alu_en ? op : 4'h0;
        bus       = take ? {10'b0, ir[5:0]} : 16'h0000;
    end
endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: fetch/decode/execute sequencer; owns the FSM, instruction register and retire counter.
module ctrl_seq
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] instr,
    input  logic        zero,
    output logic        pc_start,
    output logic        pc_inc,
    output logic        pc_branch,
    output logic [15:0] bus,
    output logic        alu_en,
    output logic [3:0]  alu_op,
    output logic [15:0] ir,
    output logic        done,
    output logic [15:0] instr_cnt
);
    state_t state, state_nx;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ir        <= 16'h0000;
            instr_cnt <= 16'h0000;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) ir <= instr;
            if (state == S_LOAD) instr_cnt <= 16'h0000;
            else if (state == S_EXEC && instr_cnt != 16'hFFFF) instr_cnt <= instr_cnt + 16'h1;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_HALT: state_nx = start ? S_LOAD : state;
            S_LOAD:         state_nx = S_FETCH;
            S_FETCH:        state_nx = S_DECODE;
            S_DECODE:       state_nx = S_EXEC;
            S_EXEC:         state_nx = ir[15:12] == OP_HALT ? S_HALT : S_FETCH;
            default:        state_nx = S_IDLE;
        endcase
    end
    assign done = state == S_HALT;
    ctrl_dec u_dec (
        .state     (state),
        .ir        (ir),
        .zero      (zero),
        .pc_start  (pc_start),
        .pc_inc    (pc_inc),
        .pc_branch (pc_branch),
        .bus       (bus),
        .alu_en    (alu_en),
        .alu_op    (alu_op)
    );
endmodule
